serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a-b using one full-adder slice (a + ~b + 1), LSB first.
// Ports: clk, rst (sync, active-high), start, a, b -> busy, done, diff, borrow
//        and ovf, which exists only when SERIAL_SUB_OVF_EN is defined.
// Macro SERIAL_SUB_OVF_EN: adds the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_nb;
    logic             w_sum;
    logic             w_cout;
    logic             w_accept;
    logic [WIDTH-1:0] w_res_next;

    // One full-adder slice on the current LSBs; b is inverted for subtraction.
    assign w_nb   = ~r_b[0];
    assign w_sum  = r_a[0] ^ w_nb ^ r_carry;
    assign w_cout = (r_a[0] & w_nb) | (r_a[0] & r_carry) | (w_nb & r_carry);

    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 holds the LSB.
    assign w_res_next = {w_sum, r_res[WIDTH-1:1]};

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Carry into the MSB is the carry register during the last slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_SHIFT && r_cnt == LAST) begin
            r_ovf <= r_carry ^ w_cout;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_res   <= w_res_next;
                    if (r_cnt == LAST) begin
                        r_diff   <= w_res_next;
                        r_borrow <= ~w_cout;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for serial_subtractor.
// Stimulus pushes expected results; a negedge monitor pops on each done pulse.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
        .borrow (borrow),
        .ovf    (ovf)
`else
        .borrow (borrow)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
        int           edge_n;
    } exp_t;

    exp_t q[$];
    int   nvec  = 0;
    int   nfail = 0;
    logic [W-1:0] held_diff = '0;

    task automatic check(input string name, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input int av, input int bv, input int n);
        exp_t e;
        int   sa;
        int   sb;
        int   sd;
        sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        sd = sa - sb;
        e.d      = W'((av - bv) & ((1 << W) - 1));
        e.br     = (av < bv);
        e.ov     = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
        e.edge_n = n;
        return e;
    endfunction

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check("diff", diff, e.d);
                check("borrow", borrow, e.br);
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", ovf, e.ov);
`endif
                check("latency", cyc, e.edge_n);
                check("busy_in_done", busy, 0);
                held_diff = diff;
            end
        end else if (!rst && busy) begin
            check("diff_hold", diff, held_diff);
        end
    end

    // Drive one start; sampled on the next rising edge (index cyc+1).
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        start = 1'b1;
        a     = av;
        b     = bv;
        q.push_back(model(int'(av), int'(bv), cyc + 1 + W));
        @(negedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        #1;
        // Start accepted on the very first edge with rst low.
        rst = 1'b0;
        issue(8'd5, 8'd3);
        wait_idle(40);
        issue(8'd3, 8'd5);
        wait_idle(40);
        issue(8'd0, 8'd0);
        wait_idle(40);
        issue(8'h80, 8'h01);
        wait_idle(40);
        issue(8'h7F, 8'hFF);
        wait_idle(40);

        // Start during SHIFT is ignored.
        issue(8'd9, 8'd4);
        @(negedge clk);
        #1;
        start = 1'b1;
        a     = 8'd1;
        b     = 8'd1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle(40);

        // Reset mid-operation aborts with no done pulse.
        issue(8'hA5, 8'h3C);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", ovf, 0);
`endif
        held_diff = '0;
        #1;
        rst = 1'b0;
        issue(8'h10, 8'h01);
        wait_idle(40);

        // start held high: accepted every W+1 cycles with fresh operands.
        start = 1'b1;
        for (int c = 0; c <= 5 * (W + 1); c++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (c % (W + 1) == 0)
                q.push_back(model(int'(a), int'(b), cyc + 1 + W));
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle(60);

        // Random operations with random idle gaps.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                #1;
            end
            issue(W'($urandom), W'($urandom));
            wait_idle(40);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
